// File: rtl/bt_cmd_pkg.sv
// Shared command byte constants, acknowledge codes and FSM state type for
// the Bluetooth remote command decoder.
package bt_cmd_pkg;

  localparam logic [7:0] CMD_PREV      = 8'h01;
  localparam logic [7:0] CMD_NEXT      = 8'h02;
  localparam logic [7:0] CMD_VUP       = 8'h03;
  localparam logic [7:0] CMD_VDN       = 8'h04;
  localparam logic [7:0] CMD_JUMP_BASE = 8'h05;
  localparam logic [7:0] CMD_PLAY      = 8'h10;

  localparam logic [7:0] ACK_OK_MASK = 8'h80;
  localparam logic [7:0] ACK_ERR     = 8'hEE;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StAck
  } state_e;

endpackage

// File: rtl/bt_jump_dist.sv
// Combinational jump distance from cur to tgt: linear, or shortest path
// modulo NUM_TRACKS with ties resolved forward.
module bt_jump_dist #(
  parameter int unsigned NUM_TRACKS = 7,
  parameter int unsigned TRACK_W    = 3,
  parameter int unsigned WRAP       = 0
) (
  input  logic [TRACK_W-1:0] cur_i,
  input  logic [TRACK_W-1:0] tgt_i,
  output logic [TRACK_W-1:0] prev_o,
  output logic [TRACK_W-1:0] next_o
);

  localparam int unsigned   W1  = TRACK_W + 1;
  localparam logic [TRACK_W:0] N_W = W1'(NUM_TRACKS);

  logic [TRACK_W:0] fwd_raw, back_raw, fwd, back;

  always_comb begin
    fwd_raw  = {1'b0, tgt_i} - {1'b0, cur_i};
    back_raw = {1'b0, cur_i} - {1'b0, tgt_i};
    // A set top bit means the subtraction went negative; fold back into range.
    fwd      = fwd_raw[TRACK_W]  ? fwd_raw + N_W  : fwd_raw;
    back     = back_raw[TRACK_W] ? back_raw + N_W : back_raw;
    prev_o   = '0;
    next_o   = '0;
    if (WRAP != 0) begin
      if (fwd <= back) next_o = fwd[TRACK_W-1:0];
      else             prev_o = back[TRACK_W-1:0];
    end else begin
      if (fwd_raw[TRACK_W] || (fwd_raw == '0)) prev_o = back_raw[TRACK_W-1:0];
      else                                      next_o = fwd_raw[TRACK_W-1:0];
    end
  end

endmodule

// File: rtl/bt_cmd_decoder.sv
// Decodes single-byte remote commands into action pulses, tracks volume and
// returns an acknowledge byte over a valid/ready handshake.
module bt_cmd_decoder
  import bt_cmd_pkg::*;
#(
  parameter int unsigned NUM_TRACKS = 7,
  parameter int unsigned TRACK_W    = 3,
  parameter int unsigned WRAP       = 0,
  parameter int unsigned VOL_W      = 4,
  parameter int unsigned VOL_MAX    = 15,
  parameter int unsigned VOL_INIT   = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_VALID,
  input  logic [7:0]         RX_DATA,
  input  logic [TRACK_W-1:0] CUR_TRACK,
  output logic               STEP_VALID,
  output logic [TRACK_W-1:0] STEP_PREV,
  output logic [TRACK_W-1:0] STEP_NEXT,
  output logic               VOL_UP,
  output logic               VOL_DOWN,
  output logic [VOL_W-1:0]   VOL_LEVEL,
  output logic               PLAY_PAUSE,
  output logic               TX_VALID,
  output logic [7:0]         TX_DATA,
  input  logic               TX_READY,
  output logic [7:0]         DROP_CNT
);

  localparam logic [TRACK_W:0] N_TRK    = (TRACK_W + 1)'(NUM_TRACKS);
  localparam logic [7:0]       JUMP_END = 8'(32'(CMD_JUMP_BASE) + NUM_TRACKS);
  localparam logic [VOL_W-1:0] VMAX     = VOL_W'(VOL_MAX);
  localparam logic [VOL_W-1:0] VINIT    = VOL_W'(VOL_INIT);

  state_e             state_q;
  logic [7:0]         cmd_q;
  logic [TRACK_W-1:0] cur_q;
  logic               step_valid_q, vol_up_q, vol_down_q, play_q, tx_valid_q;
  logic [TRACK_W-1:0] step_prev_q, step_next_q;
  logic [VOL_W-1:0]   vol_q;
  logic [7:0]         tx_data_q, drop_q;

  logic               step_d, vup_d, vdn_d, play_d, ok_d, cur_ok, jump_hit;
  logic [TRACK_W-1:0] prev_d, next_d, jd_prev, jd_next, tgt;
  logic [VOL_W-1:0]   vol_d;
  logic [7:0]         tx_data_d;

  // Modular subtraction keeps the low bits exact, so the target needs no wide math.
  assign tgt = cmd_q[TRACK_W-1:0] - CMD_JUMP_BASE[TRACK_W-1:0];

  bt_jump_dist #(
    .NUM_TRACKS(NUM_TRACKS),
    .TRACK_W   (TRACK_W),
    .WRAP      (WRAP)
  ) u_jump_dist (
    .cur_i (cur_q),
    .tgt_i (tgt),
    .prev_o(jd_prev),
    .next_o(jd_next)
  );

  always_comb begin
    cur_ok   = {1'b0, cur_q} < N_TRK;
    jump_hit = (cmd_q >= CMD_JUMP_BASE) && (cmd_q < JUMP_END);
    ok_d     = 1'b0;
    step_d   = 1'b0;
    prev_d   = '0;
    next_d   = '0;
    vup_d    = 1'b0;
    vdn_d    = 1'b0;
    play_d   = 1'b0;
    vol_d    = vol_q;
    case (cmd_q)
      CMD_PREV: if (cur_ok) begin
        ok_d   = 1'b1;
        step_d = 1'b1;
        prev_d = TRACK_W'(1);
      end
      CMD_NEXT: if (cur_ok) begin
        ok_d   = 1'b1;
        step_d = 1'b1;
        next_d = TRACK_W'(1);
      end
      CMD_VUP: begin
        ok_d = 1'b1;
        if (vol_q < VMAX) begin
          vup_d = 1'b1;
          vol_d = vol_q + VOL_W'(1);
        end
      end
      CMD_VDN: begin
        ok_d = 1'b1;
        if (vol_q != '0) begin
          vdn_d = 1'b1;
          vol_d = vol_q - VOL_W'(1);
        end
      end
      CMD_PLAY: begin
        ok_d   = 1'b1;
        play_d = 1'b1;
      end
      default: if (jump_hit && cur_ok) begin
        ok_d   = 1'b1;
        step_d = 1'b1;
        prev_d = jd_prev;
        next_d = jd_next;
      end
    endcase
    tx_data_d = ok_d ? (ACK_OK_MASK | cmd_q) : ACK_ERR;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      cmd_q        <= '0;
      cur_q        <= '0;
      step_valid_q <= 1'b0;
      step_prev_q  <= '0;
      step_next_q  <= '0;
      vol_up_q     <= 1'b0;
      vol_down_q   <= 1'b0;
      vol_q        <= VINIT;
      play_q       <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      drop_q       <= '0;
    end else begin
      step_valid_q <= 1'b0;
      vol_up_q     <= 1'b0;
      vol_down_q   <= 1'b0;
      play_q       <= 1'b0;
      // Bytes arriving outside IDLE, including on the ACK->IDLE edge, are lost.
      if (RX_VALID && (state_q != StIdle) && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
      case (state_q)
        StIdle: if (RX_VALID) begin
          cmd_q   <= RX_DATA;
          cur_q   <= CUR_TRACK;
          state_q <= StExec;
        end
        StExec: begin
          step_valid_q <= step_d;
          if (step_d) begin
            step_prev_q <= prev_d;
            step_next_q <= next_d;
          end
          vol_up_q   <= vup_d;
          vol_down_q <= vdn_d;
          vol_q      <= vol_d;
          play_q     <= play_d;
          tx_data_q  <= tx_data_d;
          tx_valid_q <= 1'b1;
          state_q    <= StAck;
        end
        StAck: if (TX_READY) begin
          tx_valid_q <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign STEP_VALID = step_valid_q;
  assign STEP_PREV  = step_prev_q;
  assign STEP_NEXT  = step_next_q;
  assign VOL_UP     = vol_up_q;
  assign VOL_DOWN   = vol_down_q;
  assign VOL_LEVEL  = vol_q;
  assign PLAY_PAUSE = play_q;
  assign TX_VALID   = tx_valid_q;
  assign TX_DATA    = tx_data_q;
  assign DROP_CNT   = drop_q;

endmodule

// File: doc/bt_cmd_decoder.md
Name: bt_cmd_decoder

Overview:
- Parametrised successor to the Bluetooth command decoder. It sits between the UART receiver byte stream and the MP3 player control logic.
- Decodes single-byte remote commands into one-cycle action pulses: track step, direct track jump, volume, play/pause.
- Keeps a saturating volume level. Computes jump distances with optional wrap-around shortest path.
- Returns a one-byte acknowledge to the UART transmitter through a valid/ready handshake.

Parameters:
- NUM_TRACKS, 7, number of tracks; legal range 2..11.
- TRACK_W, 3, track index width; requires 2^TRACK_W >= NUM_TRACKS.
- WRAP, 0, 0 = linear jump distance; 1 = shortest path modulo NUM_TRACKS.
- VOL_W, 4, volume level width.
- VOL_MAX, 15, upper saturation limit of the volume level.
- VOL_INIT, 8, volume level after reset.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset: synchronous, active-high.
- RX_VALID  in  1  one-cycle strobe; RX_DATA holds a complete received byte.
- RX_DATA  in  8  received command byte.
- CUR_TRACK  in  TRACK_W  currently playing track index.
- STEP_VALID  out  1  one-cycle pulse; a new STEP_PREV/STEP_NEXT pair is valid.
- STEP_PREV  out  TRACK_W  tracks to move backward; held until the next step.
- STEP_NEXT  out  TRACK_W  tracks to move forward; held until the next step.
- VOL_UP  out  1  one-cycle pulse when the level actually incremented.
- VOL_DOWN  out  1  one-cycle pulse when the level actually decremented.
- VOL_LEVEL  out  VOL_W  current volume level.
- PLAY_PAUSE  out  1  one-cycle toggle pulse.
- TX_VALID  out  1  acknowledge byte pending.
- TX_DATA  out  8  acknowledge byte.
- TX_READY  in  1  transmitter accepts TX_DATA while TX_VALID=1.
- DROP_CNT  out  8  saturating count of bytes dropped while busy.

Behaviour:
- Reset values: all pulses 0, STEP_PREV=0, STEP_NEXT=0, VOL_LEVEL=VOL_INIT, TX_VALID=0, TX_DATA=0, DROP_CNT=0, state IDLE.
- Reset mid-operation aborts any pending acknowledge. TX_VALID drops on the next edge.
- FSM states:
  - IDLE: on RX_VALID, latch RX_DATA and CUR_TRACK, then go to EXEC.
  - EXEC: one cycle. Decode the latched byte and register the outputs, then go to ACK.
  - ACK: TX_VALID=1 and TX_DATA stable. On TX_READY, go to IDLE.
- Latency: byte strobed in cycle T; action pulses and TX_VALID are visible in cycle T+2.
- Pulse outputs are high for exactly one cycle.
- RX_VALID in EXEC or ACK: the byte is dropped and DROP_CNT increments, saturating at 255. It never reaches the FSM.
- RX_VALID coincident with the ACK-to-IDLE transition is also dropped.
- Command map:
  - 0x01: PREV=1, NEXT=0.
  - 0x02: NEXT=1, PREV=0.
  - 0x03: volume up.
  - 0x04: volume down.
  - 0x05+k, for k < NUM_TRACKS: jump to track k.
  - 0x10: PLAY_PAUSE pulse.
  - Any other byte is invalid.
- Jump distance, WRAP=0: if k <= cur then PREV=cur-k, NEXT=0; else PREV=0, NEXT=k-cur.
- Jump distance, WRAP=1:
  - fwd=(k-cur) mod NUM_TRACKS; back=(cur-k) mod NUM_TRACKS.
  - If fwd <= back then NEXT=fwd, PREV=0; else PREV=back, NEXT=0. Ties go forward.
- Jump to the current track: STEP_VALID pulses with PREV=NEXT=0.
- Latched CUR_TRACK >= NUM_TRACKS on a step or jump command: treated as invalid; no STEP_VALID.
- Volume: saturates at 0 and VOL_MAX. At a limit there is no pulse and the level is unchanged, but the ACK is still "ok".
- STEP_PREV/STEP_NEXT change only on STEP_VALID. Volume and play commands leave them untouched.
- Acknowledge byte: valid command sends 0x80|cmd; invalid byte sends 0xEE.
- Arithmetic: the mod is computed as subtract-then-conditional-add NUM_TRACKS, in TRACK_W+1 bits. No divider.

Decomposition:
- Package bt_cmd_pkg holds: command byte constants (CMD_PREV, CMD_NEXT, CMD_VUP, CMD_VDN, CMD_JUMP_BASE, CMD_PLAY), ACK_OK_MASK=0x80, ACK_ERR=0xEE, and the FSM state enum.
- Sub-module bt_jump_dist: combinational. Inputs cur, tgt; outputs prev, next; parametrised by NUM_TRACKS, TRACK_W, WRAP.

Test Plan:
- Reset, then idle 10 cycles -> VOL_LEVEL=8, all pulses 0, TX_VALID=0, DROP_CNT=0.
- RX 0x02 at T with CUR_TRACK=3, TX_READY=1 -> STEP_VALID at T+2 with PREV=0, NEXT=1; TX_DATA=0x82 for one cycle; back to IDLE at T+3.
- WRAP=0, CUR_TRACK=5, RX 0x06 (k=1) -> PREV=4, NEXT=0. With WRAP=1, same stimulus -> NEXT=3, PREV=0.
- Eight RX 0x03 from VOL_LEVEL=8 -> seven VOL_UP pulses, VOL_LEVEL=15, eighth command gives no pulse but TX_DATA=0x83.
- Hold TX_READY=0 for 20 cycles and strobe RX 0x01 twice during ACK -> TX_VALID held, DROP_CNT=2, no extra STEP_VALID.
- RX 0x0C (k=7, out of range) -> TX_DATA=0xEE, no pulses. Assert RST during that ACK -> TX_VALID=0 next cycle, all outputs at reset values.
